// File: rtl/sector_buffer_loader_if.sv
// Bus bundle for sector_buffer_loader: the byte-stream write side, the
// picker-facing read port, and the status outputs.
// The slave modport is the loader's view; the master modport is the
// view of the block that drives the stream and the reads.
interface sector_buffer_loader_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       DIN;
    logic             DVALID;
    logic             DREADY;
    logic [8:0]       ADDR;
    logic             RENA;
    logic [7:0]       RDATA;
    logic             SECRDY;
    logic             RELEASE;
    logic [15:0]      CHKSUM;
    logic [CNT_W-1:0] SECCNT;
    logic             OVF;

    modport slave (
        input  DIN, DVALID, ADDR, RENA, RELEASE,
        output DREADY, RDATA, SECRDY, CHKSUM, SECCNT, OVF
    );

    modport master (
        output DIN, DVALID, ADDR, RENA, RELEASE,
        input  DREADY, RDATA, SECRDY, CHKSUM, SECCNT, OVF
    );
endinterface

// File: rtl/sector_buffer_loader.sv
// sector_buffer_loader: double-buffered 512-byte sector store.
// One bank fills from the byte stream while the other is read by the
// sector byte picker. A completed sector is flagged on SECRDY and handed
// back by a RELEASE pulse.
// Optional feature macro: SECTOR_CHECKSUM_EN adds a 16-bit additive
// checksum per sector. Without it CHKSUM is tied to zero.
module sector_buffer_loader #(
    parameter int SECTOR_BYTES = 512,
    parameter int CNT_W        = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    sector_buffer_loader_if.slave bus
);

    localparam int AW = $clog2(SECTOR_BYTES);

    typedef enum logic [0:0] {
        W_FILL = 1'b0,
        W_WAIT = 1'b1
    } wstate_t;

    wstate_t          state;
    wstate_t          state_nxt;
    logic             live;
    logic             wbank;
    logic             rbank;
    logic [AW-1:0]    wcnt;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic [CNT_W-1:0] seccnt;
    logic             ovf;
    logic [7:0]       rdata;
    logic [15:0]      chksum;

    logic             dready;
    logic             secrdy;
    logic             accept;
    logic             last_byte;
    logic             complete;
    logic             rel;

    // Both banks live in one array; the top address bit is the bank select.
    logic [7:0]       mem [0:2*SECTOR_BYTES-1];

    // Full-bank count after one edge: a completion adds a bank, an honoured
    // release removes one, and both together leave the count unchanged.
    function automatic logic [1:0] full_next(input logic [1:0] cur,
                                             input logic       add,
                                             input logic       sub);
        logic [1:0] res;
        res = cur;
        if (add && !sub) begin
            res = cur + 2'd1;
        end else if (sub && !add) begin
            res = cur - 2'd1;
        end
        return res;
    endfunction

    // live is low during reset and for no longer, so DREADY stays low while
    // RST is held and comes up on the first edge after release.
    assign dready    = (state == W_FILL) && live;
    assign secrdy    = (full != 2'd0);
    assign accept    = bus.DVALID && dready;
    assign last_byte = (wcnt == AW'(SECTOR_BYTES - 1));
    assign complete  = accept && last_byte;
    assign rel       = bus.RELEASE && secrdy;
    assign full_nxt  = full_next(full, complete, rel);

    // Writer FSM next state: park in W_WAIT while both banks hold sectors.
    always_comb begin
        state_nxt = state;
        case (state)
            W_FILL: begin
                if (complete && (full_nxt == 2'd2)) begin
                    state_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (full_nxt != 2'd2) begin
                    state_nxt = W_FILL;
                end
            end
            default: state_nxt = W_FILL;
        endcase
    end

    // Control state: FSM, bank selects, fill offset, counters, overflow flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= W_FILL;
            live   <= 1'b0;
            wbank  <= 1'b0;
            rbank  <= 1'b0;
            wcnt   <= '0;
            full   <= 2'd0;
            seccnt <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
            full  <= full_nxt;
            if (accept) begin
                wcnt <= last_byte ? '0 : wcnt + AW'(1);
            end
            if (complete) begin
                wbank  <= ~wbank;
                seccnt <= seccnt + CNT_W'(1);
            end
            if (rel) begin
                rbank <= ~rbank;
            end
            if (bus.DVALID && !dready) begin
                ovf <= 1'b1;
            end
        end
    end

    // Sector RAM write; contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[{wbank, wcnt}] <= bus.DIN;
        end
    end

    // Registered read port: an empty read bank reads as zero, and a read in
    // the same edge as RELEASE still sees the old rbank.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata <= 8'h00;
        end else if (bus.RENA) begin
            rdata <= secrdy ? mem[{rbank, bus.ADDR}] : 8'h00;
        end
    end

`ifdef SECTOR_CHECKSUM_EN
    logic [15:0] acc;
    logic [15:0] acc_upd;
    logic [15:0] sum_bank [0:1];

    // The first byte of a sector restarts the running sum.
    assign acc_upd = ((wcnt == '0) ? 16'd0 : acc) + {8'd0, bus.DIN};

    // Running sum during fill; freeze it into the bank's slot on completion.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc         <= 16'd0;
            sum_bank[0] <= 16'd0;
            sum_bank[1] <= 16'd0;
        end else if (accept) begin
            acc <= acc_upd;
            if (last_byte) begin
                sum_bank[wbank] <= acc_upd;
            end
        end
    end

    assign chksum = secrdy ? sum_bank[rbank] : 16'h0000;
`else
    assign chksum = 16'h0000;
`endif

    assign bus.DREADY = dready;
    assign bus.SECRDY = secrdy;
    assign bus.RDATA  = rdata;
    assign bus.CHKSUM = chksum;
    assign bus.SECCNT = seccnt;
    assign bus.OVF    = ovf;

endmodule

// File: tb/tb_sector_buffer_loader.sv
// Directed bench for sector_buffer_loader: reset, fill/read, double
// buffering with overflow, simultaneous completion and release, idle
// accesses and reset in the middle of a sector.
module tb_sector_buffer_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    sector_buffer_loader_if #(.CNT_W(8)) bus ();

    sector_buffer_loader #(.SECTOR_BYTES(512), .CNT_W(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [8:0] a, output logic [7:0] d);
        bus.ADDR = a;
        bus.RENA = 1'b1;
        tick();
        bus.RENA = 1'b0;
        d = bus.RDATA;
    endtask

    task automatic pulse_release();
        bus.RELEASE = 1'b1;
        tick();
        bus.RELEASE = 1'b0;
    endtask

    // Byte pattern used for the two-sector stream.
    function automatic logic [7:0] bval(input int i);
        return 8'((i * 5) + (i >> 9) * 51);
    endfunction

    task automatic test_reset();
        bus.DIN = 8'h00; bus.DVALID = 1'b0; bus.ADDR = 9'd0;
        bus.RENA = 1'b0; bus.RELEASE = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.DREADY !== 1'b0) begin n_fail++; $display("FAIL reset_dready: got %b expected 0", bus.DREADY); end
        n_checks++; if (bus.RDATA !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", bus.RDATA); end
        n_checks++; if (bus.SECRDY !== 1'b0) begin n_fail++; $display("FAIL reset_secrdy: got %b expected 0", bus.SECRDY); end
        n_checks++; if (bus.CHKSUM !== 16'h0000) begin n_fail++; $display("FAIL reset_chksum: got %h expected 0000", bus.CHKSUM); end
        n_checks++; if (bus.SECCNT !== 8'd0) begin n_fail++; $display("FAIL reset_seccnt: got %0d expected 0", bus.SECCNT); end
        n_checks++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.OVF); end
        rst = 1'b0;
        tick();
        n_checks++; if (bus.DREADY !== 1'b1) begin n_fail++; $display("FAIL reset_dready_up: got %b expected 1", bus.DREADY); end
    endtask

    task automatic test_fill_read();
        logic [7:0] d;
        for (int i = 0; i < 512; i++) begin
            if (i == 511) begin
                n_checks++; if (bus.SECRDY !== 1'b0) begin n_fail++; $display("FAIL fill_secrdy_early: got %b expected 0", bus.SECRDY); end
            end
            bus.DIN = 8'(i);
            bus.DVALID = 1'b1;
            tick();
        end
        bus.DVALID = 1'b0;
        n_checks++; if (bus.SECRDY !== 1'b1) begin n_fail++; $display("FAIL fill_secrdy: got %b expected 1", bus.SECRDY); end
        n_checks++; if (bus.SECCNT !== 8'd1) begin n_fail++; $display("FAIL fill_seccnt: got %0d expected 1", bus.SECCNT); end
`ifdef SECTOR_CHECKSUM_EN
        n_checks++; if (bus.CHKSUM !== 16'hFF00) begin n_fail++; $display("FAIL fill_chksum: got %h expected ff00", bus.CHKSUM); end
`else
        n_checks++; if (bus.CHKSUM !== 16'h0000) begin n_fail++; $display("FAIL fill_chksum: got %h expected 0000", bus.CHKSUM); end
`endif
        do_read(9'd0, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL fill_rd0: got %h expected 00", d); end
        do_read(9'd5, d);
        n_checks++; if (d !== 8'h05) begin n_fail++; $display("FAIL fill_rd5: got %h expected 05", d); end
        do_read(9'd511, d);
        n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL fill_rd511: got %h expected ff", d); end
        bus.ADDR = 9'd0;
        tick();
        n_checks++; if (bus.RDATA !== 8'hFF) begin n_fail++; $display("FAIL fill_rd_hold: got %h expected ff", bus.RDATA); end
        pulse_release();
        n_checks++; if (bus.SECRDY !== 1'b0) begin n_fail++; $display("FAIL fill_release_secrdy: got %b expected 0", bus.SECRDY); end
        n_checks++; if (bus.CHKSUM !== 16'h0000) begin n_fail++; $display("FAIL fill_release_chksum: got %h expected 0000", bus.CHKSUM); end
    endtask

    task automatic test_double_buffer();
        logic [7:0]  d;
        logic [15:0] s0;
        logic [15:0] s1;
        s0 = 16'd0;
        s1 = 16'd0;
        for (int i = 0; i < 512; i++) s0 = s0 + {8'd0, bval(i)};
        for (int i = 512; i < 1024; i++) s1 = s1 + {8'd0, bval(i)};
        for (int i = 0; i < 1024; i++) begin
            if (i == 1023) begin
                n_checks++; if (bus.DREADY !== 1'b1) begin n_fail++; $display("FAIL dbl_dready_before: got %b expected 1", bus.DREADY); end
            end
            bus.DIN = bval(i);
            bus.DVALID = 1'b1;
            tick();
        end
        bus.DVALID = 1'b0;
        n_checks++; if (bus.DREADY !== 1'b0) begin n_fail++; $display("FAIL dbl_dready_full: got %b expected 0", bus.DREADY); end
        n_checks++; if (bus.SECRDY !== 1'b1) begin n_fail++; $display("FAIL dbl_secrdy: got %b expected 1", bus.SECRDY); end
        n_checks++; if (bus.SECCNT !== 8'd3) begin n_fail++; $display("FAIL dbl_seccnt: got %0d expected 3", bus.SECCNT); end
        n_checks++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL dbl_ovf_before: got %b expected 0", bus.OVF); end
        bus.DIN = 8'hEE;
        bus.DVALID = 1'b1;
        tick();
        bus.DVALID = 1'b0;
        n_checks++; if (bus.OVF !== 1'b1) begin n_fail++; $display("FAIL dbl_ovf: got %b expected 1", bus.OVF); end
        n_checks++; if (bus.SECCNT !== 8'd3) begin n_fail++; $display("FAIL dbl_seccnt_drop: got %0d expected 3", bus.SECCNT); end
        do_read(9'd0, d);
        n_checks++; if (d !== bval(0)) begin n_fail++; $display("FAIL dbl_rd_first: got %h expected %h", d, bval(0)); end
`ifdef SECTOR_CHECKSUM_EN
        n_checks++; if (bus.CHKSUM !== s0) begin n_fail++; $display("FAIL dbl_chksum0: got %h expected %h", bus.CHKSUM, s0); end
`endif
        pulse_release();
        n_checks++; if (bus.DREADY !== 1'b1) begin n_fail++; $display("FAIL dbl_dready_back: got %b expected 1", bus.DREADY); end
        n_checks++; if (bus.SECRDY !== 1'b1) begin n_fail++; $display("FAIL dbl_secrdy_after: got %b expected 1", bus.SECRDY); end
`ifdef SECTOR_CHECKSUM_EN
        n_checks++; if (bus.CHKSUM !== s1) begin n_fail++; $display("FAIL dbl_chksum1: got %h expected %h", bus.CHKSUM, s1); end
`endif
        do_read(9'd0, d);
        n_checks++; if (d !== 8'h33) begin n_fail++; $display("FAIL dbl_rd512: got %h expected 33", d); end
        do_read(9'd511, d);
        n_checks++; if (d !== 8'h2E) begin n_fail++; $display("FAIL dbl_rd1023: got %h expected 2e", d); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        for (int i = 0; i < 512; i++) begin
            bus.DIN = 8'(i + 8'h11);
            bus.DVALID = 1'b1;
            if (i == 511) begin
                bus.RELEASE = 1'b1;
                bus.RENA = 1'b1;
                bus.ADDR = 9'd0;
            end
            tick();
        end
        bus.DVALID = 1'b0;
        bus.RELEASE = 1'b0;
        bus.RENA = 1'b0;
        n_checks++; if (bus.RDATA !== 8'h33) begin n_fail++; $display("FAIL sim_rd_old_bank: got %h expected 33", bus.RDATA); end
        n_checks++; if (bus.SECRDY !== 1'b1) begin n_fail++; $display("FAIL sim_secrdy: got %b expected 1", bus.SECRDY); end
        n_checks++; if (bus.DREADY !== 1'b1) begin n_fail++; $display("FAIL sim_dready: got %b expected 1", bus.DREADY); end
        n_checks++; if (bus.SECCNT !== 8'd4) begin n_fail++; $display("FAIL sim_seccnt: got %0d expected 4", bus.SECCNT); end
`ifdef SECTOR_CHECKSUM_EN
        n_checks++; if (bus.CHKSUM !== 16'hFF00) begin n_fail++; $display("FAIL sim_chksum: got %h expected ff00", bus.CHKSUM); end
`endif
        do_read(9'd0, d);
        n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL sim_rd0: got %h expected 11", d); end
        do_read(9'd511, d);
        n_checks++; if (d !== 8'h10) begin n_fail++; $display("FAIL sim_rd511: got %h expected 10", d); end
        pulse_release();
        n_checks++; if (bus.SECRDY !== 1'b0) begin n_fail++; $display("FAIL sim_release_secrdy: got %b expected 0", bus.SECRDY); end
    endtask

    task automatic test_idle();
        logic [7:0] d;
        pulse_release();
        n_checks++; if (bus.SECRDY !== 1'b0) begin n_fail++; $display("FAIL idle_secrdy: got %b expected 0", bus.SECRDY); end
        n_checks++; if (bus.DREADY !== 1'b1) begin n_fail++; $display("FAIL idle_dready: got %b expected 1", bus.DREADY); end
        n_checks++; if (bus.SECCNT !== 8'd4) begin n_fail++; $display("FAIL idle_seccnt: got %0d expected 4", bus.SECCNT); end
        n_checks++; if (bus.CHKSUM !== 16'h0000) begin n_fail++; $display("FAIL idle_chksum: got %h expected 0000", bus.CHKSUM); end
        n_checks++; if (bus.RDATA !== 8'h10) begin n_fail++; $display("FAIL idle_rdata_hold: got %h expected 10", bus.RDATA); end
        do_read(9'd0, d);
        n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL idle_rd_empty: got %h expected 00", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 0; i < 300; i++) begin
            bus.DIN = 8'hC3;
            bus.DVALID = 1'b1;
            tick();
        end
        bus.DVALID = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (bus.SECCNT !== 8'd0) begin n_fail++; $display("FAIL rmid_seccnt_reset: got %0d expected 0", bus.SECCNT); end
        n_checks++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf_reset: got %b expected 0", bus.OVF); end
        n_checks++; if (bus.SECRDY !== 1'b0) begin n_fail++; $display("FAIL rmid_secrdy_reset: got %b expected 0", bus.SECRDY); end
        for (int i = 0; i < 512; i++) begin
            if (i == 511) begin
                n_checks++; if (bus.SECRDY !== 1'b0) begin n_fail++; $display("FAIL rmid_secrdy_early: got %b expected 0", bus.SECRDY); end
            end
            bus.DIN = 8'(i) ^ 8'hA5;
            bus.DVALID = 1'b1;
            tick();
        end
        bus.DVALID = 1'b0;
        n_checks++; if (bus.SECRDY !== 1'b1) begin n_fail++; $display("FAIL rmid_secrdy: got %b expected 1", bus.SECRDY); end
        n_checks++; if (bus.SECCNT !== 8'd1) begin n_fail++; $display("FAIL rmid_seccnt: got %0d expected 1", bus.SECCNT); end
        do_read(9'd0, d);
        n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL rmid_rd0: got %h expected a5", d); end
        e = 8'h8E;
        do_read(9'd299, d);
        n_checks++; if (d !== e) begin n_fail++; $display("FAIL rmid_rd299: got %h expected %h", d, e); end
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_double_buffer();
        test_simultaneous();
        test_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sector_buffer_loader.md
# sector_buffer_loader

Double-buffered 512-byte sector store sitting directly upstream of the sector byte picker. It accepts a byte stream from the storage interface, fills one 512×8 bank while the other is being read, and flags a completed sector to the consumer. The read port (9-bit address, read enable, 8-bit data) matches what the picker drives and samples. An optional per-sector additive checksum is computed during the fill.

## Interface
- SECTOR_BYTES, 512: bytes per sector; fixed, sets the 9-bit address width.
- CNT_W, 8: width of the completed-sector counter.

- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- DIN  in  8  input byte.
- DVALID  in  1  DIN valid this cycle.
- DREADY  out  1  loader can accept a byte; transfer occurs when DVALID && DREADY at a rising edge.
- ADDR  in  9  read address within the read bank.
- RENA  in  1  read enable.
- RDATA  out  8  registered read data.
- SECRDY  out  1  at least one full sector is available in the read bank.
- RELEASE  in  1  single-cycle pulse: consumer is finished with the read bank.
- CHKSUM  out  16  checksum of the sector in the read bank; 0 when the feature is compiled out.
- SECCNT  out  CNT_W  count of completed sectors; wraps modulo 2^CNT_W.
- OVF  out  1  sticky: DVALID was high while DREADY was low; cleared only by RST.

## Operation
- Storage: two banks of 512×8, bank0 and bank1. RAM contents are not reset.
- State:
  - wbank: 1-bit write-bank select.
  - rbank: 1-bit read-bank select.
  - wcnt: 9-bit write offset.
  - full: 2-bit count of full banks, range 0..2.
- Writer FSM:
  - W_FILL: each accepted byte is written to wbank[wcnt], then wcnt increments. On the byte with wcnt=511: wcnt wraps to 0, wbank toggles, full increments, SECCNT increments. If full becomes 2, go to W_WAIT; otherwise stay in W_FILL.
  - W_WAIT: nothing is accepted. Return to W_FILL at the edge where full drops below 2.
- DREADY = (state == W_FILL). It is registered-state-derived and never depends combinationally on DVALID.
- SECRDY = (full != 0).
- Reader:
  - At each edge with RENA=1: RDATA <= rbank[ADDR] if SECRDY=1, otherwise 8'h00.
  - RENA=0: RDATA holds its value.
- RELEASE:
  - With SECRDY=1: rbank toggles and full decrements.
  - With SECRDY=0: ignored, no state change.
- Simultaneous sector completion and RELEASE in the same edge: full is unchanged, and wbank and rbank both toggle.
- A read issued in the same edge as RELEASE returns data from the old rbank.
- OVF sets on any edge with DVALID=1 and DREADY=0. The byte is dropped.

## Timing
- Reset values:
  - DREADY=0 while RST is high; DREADY=1 from the first edge after release.
  - RDATA=0, SECRDY=0, CHKSUM=0, SECCNT=0, OVF=0.
  - wcnt=0, wbank=0, rbank=0, full=0, state=W_FILL.
- Write throughput: one byte per clock; a sector takes a minimum of 512 cycles.
- SECRDY rises after the edge that accepts the 512th byte, with no extra latency.
- Read latency: one cycle. ADDR and RENA are sampled at edge N; RDATA is valid after edge N and is stable through edge N+1.
- SECRDY falls after the RELEASE edge when full goes from 1 to 0.
- DREADY reasserts after the RELEASE edge when full goes from 2 to 1.
- Reset mid-sector: the partial fill is discarded and no sector is flagged.

## Configuration
- SECTOR_CHECKSUM_EN defined:
  - Each bank has a 16-bit accumulator, cleared when wcnt=0 is written. Each accepted byte is added zero-extended, modulo 2^16.
  - The sum is frozen per bank on sector completion.
  - CHKSUM shows the frozen sum of rbank while SECRDY=1, and 0 otherwise. It updates in the same edge rbank changes.
- Undefined: no accumulators exist and CHKSUM is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Basic fill and read:
  - Stimulus: after reset, stream bytes i[7:0] for i=0..511 with DVALID continuously high.
  - Required: SECRDY=1 after byte 511 and SECCNT=1. Reads at ADDR=0, 5 and 511 return 0x00, 0x05 and 0xFF one cycle after RENA.
  - With SECTOR_CHECKSUM_EN: CHKSUM=16'hFF00.
- Double buffering:
  - Stimulus: stream 1024 bytes with no RELEASE.
  - Required: DREADY=0 after byte 1023, full=2. A 1025th DVALID sets OVF=1 and the byte is dropped.
  - Stimulus: one RELEASE.
  - Required: DREADY=1 on the next cycle. Read ADDR=0 returns byte 512's value.
- Simultaneous events:
  - Stimulus: with full=1, RELEASE on the same edge the second sector's last byte is accepted.
  - Required: full stays 1, SECRDY stays 1, and ADDR=0 then reads the second sector.
- Idle reads:
  - Stimulus: RELEASE while SECRDY=0.
  - Required: no change to any state.
  - Stimulus: RENA with SECRDY=0.
  - Required: RDATA=0x00.
- Reset mid-operation:
  - Stimulus: assert RST after 300 bytes, then stream 512 bytes.
  - Required: SECRDY rises only after the 512th post-reset byte, and SECCNT=1.
